// File: rtl/timer_counter.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, one-shot or auto-reload, level IRQ.
// Optional macro TIMER_IRQ_STATUS_EN exposes pending at offset 0xC with write-1-to-clear.
module timer_counter #(
  parameter logic [31:0] PRESET_INIT = 32'd0,
  parameter int          CTRL_BITS   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic        IRQ
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  // Unimplemented CTRL bits are held at zero by masking every write.
  localparam logic [3:0] CTRL_MASK = (CTRL_BITS >= 4) ? 4'hF
                                   : 4'((32'd1 << CTRL_BITS) - 32'd1);

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pending_q, pending_d;
  logic        irq_q;
  logic        fsm_set, fsm_clr, wr_clr;
  logic        enable, mode_reload;
  logic [1:0]  reg_sel;
  logic        unused_addr;

  assign reg_sel     = Addr[1:0];
  assign unused_addr = ^Addr[29:2];
  assign enable      = ctrl_q[0];
  assign mode_reload = (ctrl_q[2:1] == 2'd1);

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    preset_d  = preset_q;
    count_d   = count_q;
    pending_d = pending_q;
    fsm_set   = 1'b0;
    fsm_clr   = 1'b0;
    wr_clr    = 1'b0;

    case (state_q)
      S_IDLE: if (enable) state_d = S_LOAD;
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = 32'd0;
          fsm_set = 1'b1;
          state_d = S_INT;
        end
      end
      S_INT: begin
        if (mode_reload) fsm_clr = 1'b1;
        else             ctrl_d[0] = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Bus writes are applied after the FSM so a written Enable overrides the one-shot clear.
    if (WE) begin
      case (reg_sel)
        2'd0: begin
          ctrl_d = WData[3:0] & CTRL_MASK;
`ifndef TIMER_IRQ_STATUS_EN
          wr_clr = 1'b1;
`endif
        end
        2'd1: preset_d = WData;
        2'd3: begin
`ifdef TIMER_IRQ_STATUS_EN
          wr_clr = WData[0];
`endif
        end
        default: ;
      endcase
    end

    if (fsm_set)               pending_d = 1'b1;
    else if (fsm_clr || wr_clr) pending_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ctrl_q    <= 4'd0;
      preset_q  <= PRESET_INIT;
      count_q   <= 32'd0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      irq_q     <= ctrl_d[3] & pending_d;
    end
  end

  always_comb begin
    RData = 32'd0;
    case (reg_sel)
      2'd0: RData = {28'd0, ctrl_q};
      2'd1: RData = preset_q;
      2'd2: RData = count_q;
      2'd3: begin
`ifdef TIMER_IRQ_STATUS_EN
        RData = {31'd0, pending_q};
`else
        RData = 32'd0;
`endif
      end
      default: RData = 32'd0;
    endcase
  end

  assign IRQ = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed literal checks plus a randomized run against a timeline model.
module tb_timer_counter;

  localparam logic [31:0] P_INIT = 32'h0000_0007;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] WData;
  logic [31:0] RData;
  logic        IRQ;

  int n_tests = 0;
  int n_fail  = 0;

  timer_counter #(.PRESET_INIT(P_INIT), .CTRL_BITS(4)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE),
    .WData(WData), .RData(RData), .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  // Model: the timer is either idle or armed; when armed, 'age' counts edges since arming
  // and COUNT/pending/IRQ follow from age and the latched preset by plain arithmetic.
  logic [3:0]  m_ctrl    = 4'd0;
  logic [31:0] m_preset  = P_INIT;
  logic [31:0] m_count   = 32'd0;
  logic        m_pending = 1'b0;
  logic        m_armed   = 1'b0;
  logic [31:0] m_age     = 32'd0;
  logic [31:0] m_load    = 32'd0;

  always @(posedge clk) begin
    logic [3:0]  n_ctrl;
    logic [31:0] n_preset, n_count, a, span;
    logic        n_armed, set_p, clr_p;
    n_ctrl = m_ctrl; n_preset = m_preset; n_count = m_count;
    n_armed = m_armed; set_p = 1'b0; clr_p = 1'b0;
    a = m_age + 32'd1;
    span = (m_load == 32'd0) ? 32'd1 : m_load;
    if (!m_armed) begin
      if (m_ctrl[0]) begin n_armed = 1'b1; a = 32'd0; end
    end else if (a == 32'd1) begin
      n_count = m_preset;
      m_load <= m_preset;
    end else if (a <= span + 32'd1) begin
      if (!m_ctrl[0]) n_armed = 1'b0;
      else if (a == span + 32'd1) begin n_count = 32'd0; set_p = 1'b1; end
      else n_count = m_load - (a - 32'd1);
    end else begin
      if (m_ctrl[2:1] == 2'd1) clr_p = 1'b1;
      else n_ctrl[0] = 1'b0;
      n_armed = 1'b0;
    end
    if (WE) begin
      if (Addr[1:0] == 2'd0) begin
        n_ctrl = WData[3:0];
`ifndef TIMER_IRQ_STATUS_EN
        clr_p = 1'b1;
`endif
      end else if (Addr[1:0] == 2'd1) begin
        n_preset = WData;
`ifdef TIMER_IRQ_STATUS_EN
      end else if (Addr[1:0] == 2'd3) begin
        if (WData[0]) clr_p = 1'b1;
`endif
      end
    end
    if (reset) begin
      m_ctrl <= 4'd0; m_preset <= P_INIT; m_count <= 32'd0;
      m_pending <= 1'b0; m_armed <= 1'b0; m_age <= 32'd0;
    end else begin
      m_ctrl <= n_ctrl; m_preset <= n_preset; m_count <= n_count;
      m_pending <= set_p ? 1'b1 : (clr_p ? 1'b0 : m_pending);
      m_armed <= n_armed; m_age <= a;
    end
  end

  function automatic logic [31:0] mread(input logic [1:0] sel);
    case (sel)
      2'd0: return {28'd0, m_ctrl};
      2'd1: return m_preset;
      2'd2: return m_count;
`ifdef TIMER_IRQ_STATUS_EN
      default: return {31'd0, m_pending};
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of the DUT against the model, just after each edge.
  always @(posedge clk) begin
    #1;
    chk("rdata_vs_model", RData, mread(Addr[1:0]));
    chk("irq_vs_model", {31'd0, IRQ}, {31'd0, m_ctrl[3] & m_pending});
  end

  function automatic logic [29:0] mkaddr(input logic [1:0] sel);
    logic [27:0] hi;
    hi = 28'($urandom);
    return {hi, sel};
  endfunction

  // Callers sit in the low phase; the write lands on the next rising edge.
  task automatic wr(input logic [1:0] sel, input logic [31:0] d);
    Addr = mkaddr(sel); WE = 1'b1; WData = d;
    @(negedge clk);
    WE = 1'b0;
  endtask

  task automatic rd(input logic [1:0] sel, output logic [31:0] d);
    Addr = mkaddr(sel);
    #1 d = RData;
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] hits;
    logic        any_irq;
    reset = 1'b1; WE = 1'b0; Addr = '0; WData = '0;
    step(2);
    reset = 1'b0;

    rd(2'd0, v); chk("reset_ctrl", v, 32'd0);
    rd(2'd1, v); chk("reset_preset", v, P_INIT);
    rd(2'd2, v); chk("reset_count", v, 32'd0);
    chk("reset_irq", {31'd0, IRQ}, 32'd0);

    // One-shot, PRESET=5
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    step(2); rd(2'd2, v); chk("oneshot_count_t2", v, 32'd5);
    step(4); rd(2'd2, v); chk("oneshot_count_t6", v, 32'd1);
    chk("oneshot_irq_t6", {31'd0, IRQ}, 32'd0);
    step(1); rd(2'd2, v); chk("oneshot_count_t7", v, 32'd0);
    chk("oneshot_irq_t7", {31'd0, IRQ}, 32'd1);
    step(1); rd(2'd0, v); chk("oneshot_ctrl_t8", v, 32'h8);
    step(3); chk("oneshot_irq_held", {31'd0, IRQ}, 32'd1);
`ifdef TIMER_IRQ_STATUS_EN
    wr(2'd3, 32'd1);
`else
    wr(2'd0, 32'h8);
`endif
    chk("oneshot_irq_cleared", {31'd0, IRQ}, 32'd0);

    // Auto-reload, PRESET=3: one-cycle pulses 6 cycles apart
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    hits = 32'd0;
    for (int k = 1; k <= 18; k++) begin
      step(1);
      if (IRQ) hits[k] = 1'b1;
    end
    chk("reload_irq_pattern", hits, (32'd1 << 5) | (32'd1 << 11) | (32'd1 << 17));
    rd(2'd0, v); chk("reload_ctrl_enable", v, 32'hB);
    wr(2'd0, 32'h0);
    step(3);

    // Masked: fires but IRQ stays low
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    any_irq = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      any_irq = any_irq | IRQ;
    end
    chk("masked_irq_never", {31'd0, any_irq}, 32'd0);
    rd(2'd0, v); chk("masked_ctrl_after_fire", v, 32'd0);

    // Pause and re-enable
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    step(4); rd(2'd2, v); chk("pause_count_t4", v, 32'd8);
    wr(2'd0, 32'h0);
    rd(2'd2, v); chk("pause_count_t5", v, 32'd7);
    step(3); rd(2'd2, v); chk("pause_frozen", v, 32'd7);
    wr(2'd0, 32'h1);
    step(1); rd(2'd2, v); chk("resume_before_load", v, 32'd7);
    step(1); rd(2'd2, v); chk("resume_reloaded", v, 32'd10);
    wr(2'd0, 32'h0);
    step(1);
    wr(2'd2, 32'hFFFF_FFFF);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd2, v); chk("count_write_ignored", v, 32'd9);
    rd(2'd3, v); chk("offset_c_reads_zero", v, 32'd0);
    rd(2'd1, v); chk("preset_kept", v, 32'd10);

    // PRESET=0 behaves as 1
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    step(2); chk("preset0_irq_t2", {31'd0, IRQ}, 32'd0);
    step(1); chk("preset0_irq_t3", {31'd0, IRQ}, 32'd1);
`ifdef TIMER_IRQ_STATUS_EN
    rd(2'd3, v); chk("status_pending", v, 32'd1);
    wr(2'd3, 32'd1);
    chk("status_clear_irq", {31'd0, IRQ}, 32'd0);
`else
    wr(2'd0, 32'h8);
    chk("ctrl_clear_irq", {31'd0, IRQ}, 32'd0);
`endif

    // Randomized traffic, including mid-count resets
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 199) == 0);
      WE    = ($urandom_range(0, 3) == 0);
      Addr  = mkaddr(2'($urandom_range(0, 3)));
      case (Addr[1:0])
        2'd0: WData = {28'($urandom), 1'($urandom), 2'($urandom),
                       1'($urandom_range(0, 4) != 0)};
        2'd1: WData = 32'($urandom_range(0, 6));
        default: WData = $urandom;
      endcase
      if (WE && Addr[1:0] == 2'd0 && $urandom_range(0, 1) == 0) WE = 1'b0;
    end
    @(negedge clk);
    reset = 1'b0; WE = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
